// File: rtl/alu_wb_arbiter_pkg.sv
// alu_wb_arbiter_pkg: shared types for the ALU writeback arbiter
package alu_wb_arbiter_pkg;
    localparam int ALU_WB_UNITS = 4;
    localparam int DATA_W = 32;
    localparam int INDEX_W = 6;
    localparam int ISSUE_W = 8;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [ISSUE_W-1:0] issue_no_t;
    typedef enum logic [1:0] {UNIT_MA, UNIT_IDIV, UNIT_CNVT, UNIT_SRL} unit_id_e;
    typedef struct packed {
        data_t data;
        index_t index;
        issue_no_t issue_no;
    } wb_entry_t;
endpackage

// File: rtl/alu_wb_arbiter_fifo.sv
// wb_result_fifo: per-unit result queue; a push into a full queue is kept only when the head leaves at the same edge
module wb_result_fifo
    import alu_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty,
    output logic      dropped
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    wb_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic do_pop, do_push;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    assign dropped = push && !do_push;
    // pointer/count bookkeeping; a full queue's write slot equals the head slot being vacated
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/alu_wb_arbiter.sv
// alu_wb_arbiter: queues ALU sub-unit results and writes back the oldest by wrap-aware issue number
module alu_wb_arbiter
    import alu_wb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = ALU_WB_UNITS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  issue_no_t            I_Issue_No,
    input  logic                 I_Stall,
    input  logic [NUM_UNITS-1:0] I_Valid,
    input  data_t                I_Data    [NUM_UNITS],
    input  index_t               I_Index   [NUM_UNITS],
    input  issue_no_t            I_IssueNo [NUM_UNITS],
    output logic [NUM_UNITS-1:0] O_Unit_Full,
    output logic                 O_Overflow,
    output logic                 O_ALU_Done,
    output data_t                O_WB_Data,
    output index_t               O_WB_Index,
    output issue_no_t            O_WB_IssueNo,
    output logic [NUM_UNITS-1:0] O_Grant
);
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    wb_entry_t heads [NUM_UNITS];
    issue_no_t age [NUM_UNITS];
    logic [NUM_UNITS-1:0] empty, pop, drop;
    logic [UW-1:0] win;
    logic any;
    issue_no_t best;
    wb_entry_t wb_q;
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_fifo
        wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock  (clock),
            .reset  (reset),
            .push   (I_Valid[g]),
            .pop    (pop[g]),
            .din    ('{data: I_Data[g], index: I_Index[g], issue_no: I_IssueNo[g]}),
            .head   (heads[g]),
            .full   (O_Unit_Full[g]),
            .empty  (empty[g]),
            .dropped(drop[g])
        );
    end
    // oldest non-empty head wins; strict compare keeps ties on the lowest unit
    always_comb begin
        win = '0;
        best = '0;
        any = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            age[u] = I_Issue_No - heads[u].issue_no;
            if (!empty[u] && (!any || age[u] > best)) begin
                any = 1'b1;
                win = UW'(u);
                best = age[u];
            end
        end
        pop = (!I_Stall && any) ? NUM_UNITS'(1) << win : '0;
    end
    // writeback register: holds under stall, otherwise takes the winner or goes idle
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_q <= '0;
            O_ALU_Done <= 1'b0;
            O_Grant <= '0;
            O_Overflow <= 1'b0;
        end else begin
            O_Overflow <= O_Overflow | (|drop);
            if (!I_Stall) begin
                O_ALU_Done <= any;
                O_Grant <= pop;
                if (any) wb_q <= heads[win];
            end
        end
    end
    assign O_WB_Data = wb_q.data;
    assign O_WB_Index = wb_q.index;
    assign O_WB_IssueNo = wb_q.issue_no;
endmodule
